alu64_registered: RTL and testbench

64-bit two's-complement ALU with a registered result and NZVC-style flags, built from 64 chained 1-bit `bitslice` cells and a `testZero` 64-input zero detector. It is the execute-stage arithmetic/logic unit of the single-issue ARM-subset datapath. Operands and the opcode are captured on a clock edge, and the result and flags are presented one cycle later.

---
 rtl/alu64_registered.sv | 151 +++++++++++++++
 tb/tb_alu64_registered.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alu64_registered.sv
// 64-bit ripple ALU with registered result and NZVC flags; one-cycle latency.
// Optional macro ALU_FLAG_HOLD_EN: overflow/carry_out hold on non-add/sub ops.

module bitslice (
   input  logic       a_i,
   input  logic       b_i,
   input  logic       ci_i,
   input  logic [2:0] cntrl_i,
   output logic       res_o,
   output logic       co_o
);
   logic bx;
   logic sum;

   always_comb begin
      bx    = b_i ^ cntrl_i[0];
      sum   = a_i ^ bx ^ ci_i;
      co_o  = (a_i & bx) | (ci_i & (a_i ^ bx));
      res_o = 1'b0;
      case (cntrl_i)
         3'b000:         res_o = b_i;
         3'b010, 3'b011: res_o = sum;
         3'b100:         res_o = a_i & b_i;
         3'b101:         res_o = a_i | b_i;
         3'b110:         res_o = a_i ^ b_i;
         default:        res_o = 1'b0;
      endcase
   end
endmodule

module testZero (
   input  logic [63:0] data_i,
   output logic        zero_o
);
   logic [31:0] l1;
   logic [15:0] l2;
   logic [7:0]  l3;
   logic [3:0]  l4;
   logic [1:0]  l5;

   // Balanced OR tree, inverted at the root.
   always_comb begin
      l1 = '0;
      l2 = '0;
      l3 = '0;
      l4 = '0;
      l5 = '0;
      for (int unsigned i = 0; i < 32; i++) l1[i] = data_i[2*i] | data_i[2*i+1];
      for (int unsigned i = 0; i < 16; i++) l2[i] = l1[2*i] | l1[2*i+1];
      for (int unsigned i = 0; i < 8; i++)  l3[i] = l2[2*i] | l2[2*i+1];
      for (int unsigned i = 0; i < 4; i++)  l4[i] = l3[2*i] | l3[2*i+1];
      for (int unsigned i = 0; i < 2; i++)  l5[i] = l4[2*i] | l4[2*i+1];
      zero_o = ~(l5[0] | l5[1]);
   end
endmodule

module alu64_registered (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [63:0] A,
   input  logic [63:0] B,
   input  logic [2:0]  cntrl,
   output logic        out_valid,
   output logic [63:0] result,
   output logic        negative,
   output logic        zero,
   output logic        overflow,
   output logic        carry_out
);
   logic [64:0] carry;
   logic [63:0] alu_res;
   logic        alu_zero;
   logic        is_arith;

   logic [63:0] result_d, result_q;
   logic        zero_d, zero_q;
   logic        ovf_d, ovf_q;
   logic        cout_d, cout_q;
   logic        valid_q;

   // Slice 0 carry-in equals the B-invert bit, giving A + ~B + 1 on subtract.
   assign carry[0] = cntrl[0];

   genvar gi;
   generate
      for (gi = 0; gi < 64; gi++) begin : g_slice
         bitslice u_slice (
            .a_i     (A[gi]),
            .b_i     (B[gi]),
            .ci_i    (carry[gi]),
            .cntrl_i (cntrl),
            .res_o   (alu_res[gi]),
            .co_o    (carry[gi+1])
         );
      end
   endgenerate

   testZero u_zero (
      .data_i (alu_res),
      .zero_o (alu_zero)
   );

   assign is_arith = (cntrl[2:1] == 2'b01);

   always_comb begin
      result_d = result_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      cout_d   = cout_q;
      if (in_valid) begin
         result_d = alu_res;
         zero_d   = alu_zero;
         if (is_arith) begin
            ovf_d  = carry[63] ^ carry[64];
            cout_d = carry[64];
         end else begin
`ifdef ALU_FLAG_HOLD_EN
            ovf_d  = ovf_q;
            cout_d = cout_q;
`else
            ovf_d  = 1'b0;
            cout_d = 1'b0;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         zero_q   <= 1'b1;
         ovf_q    <= 1'b0;
         cout_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         result_q <= result_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
         cout_q   <= cout_d;
         valid_q  <= in_valid;
      end
   end

   assign result    = result_q;
   assign negative  = result_q[63];
   assign zero      = zero_q;
   assign overflow  = ovf_q;
   assign carry_out = cout_q;
   assign out_valid = valid_q;
endmodule

// File: tb/tb_alu64_registered.sv
// Directed table-driven bench for alu64_registered, plus reset and abort sequences.
// Honours ALU_FLAG_HOLD_EN when expecting flags on non-add/sub opcodes.

module tb_alu64_registered;
   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [63:0] A;
   logic [63:0] B;
   logic [2:0]  cntrl;
   logic        out_valid;
   logic [63:0] result;
   logic        negative;
   logic        zero;
   logic        overflow;
   logic        carry_out;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

`ifdef ALU_FLAG_HOLD_EN
   localparam logic H = 1'b1;
`else
   localparam logic H = 1'b0;
`endif

   typedef struct {
      logic        vld;
      logic [2:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] res;
      logic        n;
      logic        z;
      logic        v;
      logic        c;
   } vec_t;

   vec_t vecs[13];

   alu64_registered dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .A         (A),
      .B         (B),
      .cntrl     (cntrl),
      .out_valid (out_valid),
      .result    (result),
      .negative  (negative),
      .zero      (zero),
      .overflow  (overflow),
      .carry_out (carry_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [63:0] r, input logic n, input logic z,
                          input logic v, input logic c, input logic ov);
      chk({tag, ".result"},    result,           r);
      chk({tag, ".negative"},  {63'd0, negative}, {63'd0, n});
      chk({tag, ".zero"},      {63'd0, zero},     {63'd0, z});
      chk({tag, ".overflow"},  {63'd0, overflow}, {63'd0, v});
      chk({tag, ".carry_out"}, {63'd0, carry_out}, {63'd0, c});
      chk({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, ov});
   endtask

   initial begin
      vecs[0]  = '{1'b1, 3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
                   64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                   64'd0, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[2]  = '{1'b1, 3'b110, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFFFF_FFFF_FFFF_FFFF,
                   64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b0, 1'b0, H};
      vecs[3]  = '{1'b1, 3'b100, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFFFF_FFFF_FFFF_FFFF,
                   64'hF0F0_F0F0_F0F0_F0F0, 1'b1, 1'b0, 1'b0, H};
      vecs[4]  = '{1'b1, 3'b000, 64'h0000_0000_0000_1234, 64'hFEDC_BA98_7654_3210,
                   64'hFEDC_BA98_7654_3210, 1'b1, 1'b0, 1'b0, H};
      vecs[5]  = '{1'b1, 3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                   64'd0, 1'b0, 1'b1, 1'b0, H};
      vecs[6]  = '{1'b1, 3'b011, 64'd5, 64'd5, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[7]  = '{1'b1, 3'b011, 64'd0, 64'd1,
                   64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 3'b101, 64'h0000_0000_0000_00FF, 64'h0000_0000_0000_FF00,
                   64'h0000_0000_0000_FFFF, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 3'b011, 64'h8000_0000_0000_0000, 64'd1,
                   64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[10] = '{1'b1, 3'b001, 64'd5, 64'd3, 64'd0, 1'b0, 1'b1, H, H};
      vecs[11] = '{1'b0, 3'b010, 64'd100, 64'd200, 64'd0, 1'b0, 1'b1, H, H};
      vecs[12] = '{1'b1, 3'b010, 64'd3, 64'd4, 64'd7, 1'b0, 1'b0, 1'b0, 1'b0};

      // Reset held with random inputs while the clock runs.
      rst_n    = 1'b0;
      in_valid = 1'b1;
      A        = {$urandom, $urandom};
      B        = {$urandom, $urandom};
      cntrl    = 3'($urandom_range(0, 7));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         A     = {$urandom, $urandom};
         B     = {$urandom, $urandom};
         cntrl = 3'($urandom_range(0, 7));
      end
      @(posedge clk);
      #1;
      chk_all("reset", 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         in_valid = vecs[i].vld;
         A        = vecs[i].a;
         B        = vecs[i].b;
         cntrl    = vecs[i].op;
         @(posedge clk);
         #1;
         chk_all($sformatf("vec%0d", i), vecs[i].res, vecs[i].n, vecs[i].z,
                 vecs[i].v, vecs[i].c, vecs[i].vld);
      end

      // Reset arriving between capture setup and the edge clears outputs at once.
      @(negedge clk);
      in_valid = 1'b1;
      A        = 64'd1;
      B        = 64'd1;
      cntrl    = 3'b010;
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("abort", 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk_all("abort_edge", 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      // First valid edge after release yields a normal result.
      @(negedge clk);
      rst_n = 1'b1;
      A     = 64'd10;
      B     = 64'd3;
      cntrl = 3'b011;
      @(posedge clk);
      #1;
      chk_all("post_reset", 64'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk_all("pulse_end", 64'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
